// File: rtl/vb_pkg.sv
// Shared definitions for the VRAM block-transfer controller: FSM state
// encodings, HDMA MMIO register addresses, block size and the FF55 read
// formatter.
package vb_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_RD    = 3'd2;
   localparam logic [2:0] ST_WR    = 3'd3;
   localparam logic [2:0] ST_HWAIT = 3'd4;

   // HDMA MMIO register addresses
   localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
   localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
   localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
   localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
   localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

   // Bytes moved per block, and the index of the last byte in a block
   localparam int         BLOCK_BYTES = 16;
   localparam logic [3:0] LAST_BYTE   = 4'(BLOCK_BYTES - 1);

   // FF55 read value: bit 7 is clear while a transfer is active
   function automatic logic [7:0] ff55_value(input logic active, input logic [6:0] len);
      return {~active, len};
   endfunction

endpackage

// File: rtl/vram_hdma.sv
// CGB-style VRAM block-transfer controller. Holds the HDMA MMIO registers
// and copies 16-byte blocks from the source bus into VRAM, either all at
// once (GDMA) or one block per horizontal blank (HDMA). Strobes are decoded
// directly from the registered FSM state.
module vram_hdma
   import vb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        rd,
   input  logic        wr,
   input  logic        hblank,
   input  logic        lcd_on,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] src_a,
   output logic        src_rd,
   input  logic [7:0]  src_din,
   output logic [12:0] vram_a,
   output logic [7:0]  vram_dout,
   output logic        vram_wr,
   output logic        cpu_stall
);

   logic [2:0]  state;
   logic [15:0] src;
   logic [12:0] dst;
   logic [6:0]  len;
   logic        hdma;
   logic        cancel;
   logic [3:0]  byte_cnt;
   logic        ff55_wr;
   logic        stop_req;

   assign ff55_wr  = wr && (a == ADDR_HDMA5);
   // A bit7=0 write to FF55 during an HDMA asks for termination
   assign stop_req = ff55_wr && !din[7];

   // FSM, address counters, remaining-length counter and MMIO register writes
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         src      <= 16'h0000;
         dst      <= 13'h0000;
         len      <= 7'h7F;
         hdma     <= 1'b0;
         cancel   <= 1'b0;
         byte_cnt <= 4'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr && (a == ADDR_HDMA1)) src[15:8] <= din;
               if (wr && (a == ADDR_HDMA2)) src[7:0]  <= {din[7:4], 4'h0};
               if (wr && (a == ADDR_HDMA3)) dst[12:8] <= din[4:0];
               if (wr && (a == ADDR_HDMA4)) dst[7:0]  <= {din[7:4], 4'h0};
               if (ff55_wr) begin
                  len      <= din[6:0];
                  hdma     <= din[7];
                  cancel   <= 1'b0;
                  byte_cnt <= 4'h0;
                  // HDMA with the LCD running waits for the first hblank
                  state    <= (din[7] && lcd_on) ? ST_HWAIT : ST_REQ;
               end
            end
            ST_HWAIT: begin
               if (stop_req || cancel) begin
                  state <= ST_IDLE;
               end else if (hblank || !lcd_on) begin
                  state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (stop_req && hdma) cancel <= 1'b1;
               if (bus_gnt) state <= ST_RD;
            end
            ST_RD: begin
               if (stop_req && hdma) cancel <= 1'b1;
               src   <= src + 16'd1;
               state <= ST_WR;
            end
            ST_WR: begin
               if (stop_req && hdma) cancel <= 1'b1;
               dst      <= dst + 13'd1;
               byte_cnt <= byte_cnt + 4'd1;
               if (byte_cnt == LAST_BYTE) begin
                  if (dst == 13'h1FFF) begin
                     // VRAM offset wrapped: the transfer ends here
                     len   <= 7'h7F;
                     state <= ST_IDLE;
                  end else begin
                     // LEN of 0 wraps to 0x7F so FF55 reads 0xFF when done
                     len <= len - 7'd1;
                     if ((len == 7'd0) || cancel || (stop_req && hdma)) begin
                        state <= ST_IDLE;
                     end else if (hdma) begin
                        state <= ST_HWAIT;
                     end else begin
                        state <= ST_REQ;
                     end
                  end
               end else begin
                  state <= ST_RD;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus_req   = (state == ST_REQ) || (state == ST_RD) || (state == ST_WR);
   assign cpu_stall = (state != ST_IDLE) && (state != ST_HWAIT);
   assign src_rd    = (state == ST_RD);
   assign src_a     = src;
   assign vram_wr   = (state == ST_WR);
   assign vram_a    = dst;
   assign vram_dout = src_din;

   // MMIO read mux: only FF55 is readable, everything else reads 0xFF
   always_comb begin
      dout = 8'hFF;
      if (rd && (a == ADDR_HDMA5)) begin
         dout = ff55_value(state != ST_IDLE, len);
      end else begin
         dout = 8'hFF;
      end
   end

endmodule

// File: tb/tb_vram_hdma.sv
// Self-checking bench for vram_hdma: a table of GDMA transfers plus
// hand-written HDMA, cancel, grant-stall and reset sequences. Expected VRAM
// writes are queued when a transfer is started and checked as they appear.
module tb_vram_hdma;
   import vb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        rd;
   logic        wr;
   logic        hblank;
   logic        lcd_on;
   logic        bus_req;
   logic        bus_gnt;
   logic [15:0] src_a;
   logic        src_rd;
   logic [7:0]  src_din;
   logic [12:0] vram_a;
   logic [7:0]  vram_dout;
   logic        vram_wr;
   logic        cpu_stall;

   logic        gnt_en;
   int          total = 0;
   int          bad = 0;
   int          wr_count = 0;

   typedef struct {
      logic [12:0] va;
      logic [7:0]  vd;
   } wr_exp_t;

   typedef struct {
      logic [15:0] src;
      logic [12:0] dst;
      logic [7:0]  ff55;
      int          blocks;
      logic [7:0]  after;
   } vec_t;

   wr_exp_t sb[$];
   wr_exp_t mon_e;

   vram_hdma dut (
      .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
      .hblank(hblank), .lcd_on(lcd_on), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .src_a(src_a), .src_rd(src_rd), .src_din(src_din), .vram_a(vram_a),
      .vram_dout(vram_dout), .vram_wr(vram_wr), .cpu_stall(cpu_stall)
   );

   always #5 clk = ~clk;

   // arbiter model: grants whenever requested unless the bench holds it off
   assign bus_gnt = bus_req & gnt_en;

   // source memory contents as a function of address
   function automatic logic [7:0] pat(input logic [15:0] ad);
      return ad[7:0] ^ {ad[11:8], ad[15:12]} ^ 8'hA5;
   endfunction

   // synchronous source RAM: data one clock after the read strobe
   always @(posedge clk) begin
      if (src_rd === 1'b1) src_din <= pat(src_a);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // scoreboard: every VRAM write must match the next queued expectation
   always @(negedge clk) begin
      if (vram_wr === 1'b1) begin
         wr_count++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%h:%h required=no write", vram_a, vram_dout);
         end else begin
            mon_e = sb.pop_front();
            chk("write_addr", 32'(vram_a), 32'(mon_e.va));
            chk("write_data", 32'(vram_dout), 32'(mon_e.vd));
         end
      end
   end

   task automatic mmio_write(input logic [15:0] ad, input logic [7:0] d);
      @(negedge clk);
      a = ad; din = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; a = 16'h0000;
   endtask

   task automatic mmio_read(input logic [15:0] ad, output logic [7:0] v);
      @(negedge clk);
      a = ad; rd = 1'b1;
      #1;
      v = dout;
      rd = 1'b0; a = 16'h0000;
   endtask

   task automatic program_regs(input logic [15:0] s, input logic [12:0] d);
      mmio_write(ADDR_HDMA1, s[15:8]);
      mmio_write(ADDR_HDMA2, s[7:0]);
      mmio_write(ADDR_HDMA3, {3'b100, d[12:8]});
      mmio_write(ADDR_HDMA4, d[7:0]);
   endtask

   task automatic push_blocks(input logic [15:0] s, input logic [12:0] d, input int n);
      wr_exp_t e;
      logic [15:0] sa;
      logic [12:0] da;
      sa = {s[15:4], 4'h0};
      da = {d[12:4], 4'h0};
      for (int i = 0; i < n * BLOCK_BYTES; i++) begin
         e.va = da + 13'(i);
         e.vd = pat(sa + 16'(i));
         sb.push_back(e);
      end
   endtask

   task automatic pulse_hblank();
      @(negedge clk);
      hblank = 1'b1;
      @(negedge clk);
      hblank = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while ((cpu_stall === 1'b1) && (cyc < 3000)) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) begin
         total++;
         bad++;
         $display("FAIL idle_timeout actual=stalled required=idle within 3000 clocks");
      end
   endtask

   initial begin
      vec_t       vecs[3];
      logic [7:0] v;
      logic [7:0] hexp[3];
      int         cyc;
      logic       held_ok;

      vecs[0] = '{src: 16'hC000, dst: 13'h0000, ff55: 8'h01, blocks: 2, after: 8'hFF};
      vecs[1] = '{src: 16'h412B, dst: 13'h0ABC, ff55: 8'h00, blocks: 1, after: 8'hFF};
      vecs[2] = '{src: 16'hD3F0, dst: 13'h1FF0, ff55: 8'h03, blocks: 1, after: 8'hFF};
      hexp[0] = 8'h01;
      hexp[1] = 8'h00;
      hexp[2] = 8'hFF;

      rst = 1'b0; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
      hblank = 1'b0; lcd_on = 1'b0; gnt_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // reset state
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_vram_wr", 32'(vram_wr), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      mmio_read(ADDR_HDMA5, v); chk("rst_ff55", 32'(v), 32'h0000_00FF);
      mmio_read(ADDR_HDMA1, v); chk("rd_ff51", 32'(v), 32'h0000_00FF);
      mmio_read(16'hFF56, v);   chk("rd_out_of_range", 32'(v), 32'h0000_00FF);

      // table of GDMA transfers, including an unaligned setup and a DST wrap
      for (int i = 0; i < 3; i++) begin
         wr_count = 0;
         program_regs(vecs[i].src, vecs[i].dst);
         push_blocks(vecs[i].src, vecs[i].dst, vecs[i].blocks);
         mmio_write(ADDR_HDMA5, vecs[i].ff55);
         chk("req_after_start", 32'(bus_req), 32'd1);
         chk("no_rd_in_req", 32'(src_rd), 32'd0);
         @(negedge clk);
         chk("first_src_rd", 32'(src_rd), 32'd1);
         wait_idle(cyc);
         chk("stall_cycles", 32'(cyc + 1), 32'(vecs[i].blocks * 33));
         chk("write_count", 32'(wr_count), 32'(vecs[i].blocks * 16));
         chk("queue_empty", 32'(sb.size()), 32'd0);
         mmio_read(ADDR_HDMA5, v);
         chk("ff55_after", 32'(v), 32'(vecs[i].after));
      end

      // HDMA: three blocks, one per hblank, nothing in between
      lcd_on = 1'b1;
      wr_count = 0;
      program_regs(16'h2340, 13'h0400);
      mmio_write(ADDR_HDMA5, 8'h82);
      repeat (20) @(negedge clk);
      chk("hdma_wait_writes", 32'(wr_count), 32'd0);
      chk("hdma_wait_stall", 32'(cpu_stall), 32'd0);
      mmio_read(ADDR_HDMA5, v); chk("hdma_ff55_start", 32'(v), 32'h0000_0002);
      for (int b = 0; b < 3; b++) begin
         push_blocks(16'h2340 + 16'(b * 16), 13'h0400 + 13'(b * 16), 1);
         wr_count = 0;
         pulse_hblank();
         chk("hblank_to_req", 32'(bus_req), 32'd1);
         if (b == 1) begin
            repeat (5) @(negedge clk);
            pulse_hblank();
         end
         wait_idle(cyc);
         repeat (20) @(negedge clk);
         chk("hdma_block_writes", 32'(wr_count), 32'd16);
         mmio_read(ADDR_HDMA5, v);
         chk("hdma_ff55", 32'(v), 32'(hexp[b]));
      end
      wr_count = 0;
      pulse_hblank();
      repeat (40) @(negedge clk);
      chk("idle_hblank_ignored", 32'(wr_count), 32'd0);

      // cancel an HDMA with LEN=5 after its first block
      wr_count = 0;
      program_regs(16'h5000, 13'h0800);
      mmio_write(ADDR_HDMA5, 8'h85);
      push_blocks(16'h5000, 13'h0800, 1);
      pulse_hblank();
      wait_idle(cyc);
      mmio_read(ADDR_HDMA5, v); chk("cancel_ff55_active", 32'(v), 32'h0000_0004);
      mmio_write(ADDR_HDMA5, 8'h00);
      mmio_read(ADDR_HDMA5, v); chk("cancel_ff55", 32'(v), 32'h0000_0084);
      pulse_hblank();
      repeat (40) @(negedge clk);
      pulse_hblank();
      repeat (40) @(negedge clk);
      chk("cancel_writes", 32'(wr_count), 32'd16);
      chk("cancel_queue_empty", 32'(sb.size()), 32'd0);

      // grant withheld for 10 clocks in REQ
      lcd_on = 1'b0;
      gnt_en = 1'b0;
      wr_count = 0;
      program_regs(16'h6660, 13'h0120);
      push_blocks(16'h6660, 13'h0120, 1);
      mmio_write(ADDR_HDMA5, 8'h00);
      held_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (!((bus_req === 1'b1) && (src_rd === 1'b0) && (vram_wr === 1'b0))) held_ok = 1'b0;
         @(negedge clk);
      end
      chk("gnt_wait_hold", 32'(held_ok), 32'd1);
      gnt_en = 1'b1;
      wait_idle(cyc);
      chk("gnt_block_writes", 32'(wr_count), 32'd16);
      chk("gnt_queue_empty", 32'(sb.size()), 32'd0);
      mmio_read(ADDR_HDMA5, v); chk("gnt_ff55", 32'(v), 32'h0000_00FF);

      // reset in the middle of a block
      program_regs(16'h4000, 13'h0100);
      push_blocks(16'h4000, 13'h0100, 1);
      mmio_write(ADDR_HDMA5, 8'h00);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_vram_wr", 32'(vram_wr), 32'd0);
      chk("midrst_bus_req", 32'(bus_req), 32'd0);
      chk("midrst_stall", 32'(cpu_stall), 32'd0);
      mmio_read(ADDR_HDMA5, v); chk("midrst_ff55", 32'(v), 32'h0000_00FF);
      // new source takes effect; destination comes back from reset as 0
      wr_count = 0;
      mmio_write(ADDR_HDMA1, 8'h12);
      mmio_write(ADDR_HDMA2, 8'h30);
      push_blocks(16'h1230, 13'h0000, 1);
      mmio_write(ADDR_HDMA5, 8'h00);
      wait_idle(cyc);
      chk("postrst_writes", 32'(wr_count), 32'd16);
      chk("postrst_queue_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
